// File: rtl/bcd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_pkg
//  Description : Shared FSM state type, blank code and seven-segment decoder
//                for the sequential BCD controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low segments ordered {g,f,e,d,c,b,a}; non-decimal codes are blank.
    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_seq_ctrl_add3.sv
`default_nettype none
// ============================================================================
//  Module      : add3
//  Description : Double-dabble nibble correction, adds 3 when nibble >= 5.
//  Revision    : 1.0 - initial release
// ============================================================================
module add3 (
    input  logic [3:0] i_nib,
    output logic [3:0] o_nib
);

    assign o_nib = (i_nib >= 4'd5) ? (i_nib + 4'd3) : i_nib;

endmodule
`default_nettype wire

// File: rtl/bcd_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_seq_ctrl
//  Description : Bit-serial binary-to-BCD converter with start/busy/done
//                handshake and a 4-digit common-anode display scanner.
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_seq_ctrl
    import bcd_pkg::*;
#(
    parameter int WIDTH    = 11,
    parameter int SCAN_DIV = 50000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] value,
    output logic             busy,
    output logic             done,
    output logic [3:0]       thousands,
    output logic [3:0]       hundreds,
    output logic [3:0]       tens,
    output logic [3:0]       ones,
    output logic [3:0]       an,
    output logic [6:0]       seg
);

    localparam int CNT_W  = $clog2(WIDTH + 1);
    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   sr_q, sr_d;
    logic [15:0]        bcd_q, bcd_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [15:0]        digits_q, digits_d;
    logic [15:0]        w_adj;

    logic [SCAN_W-1:0]  scan_cnt_q, scan_cnt_d;
    logic [1:0]         idx_q, idx_d;
    logic [3:0]         w_sel;
    logic               w_blank;

    for (genvar i = 0; i < 4; i++) begin : g_add3
        add3 u_add3 (
            .i_nib (bcd_q[4*i +: 4]),
            .o_nib (w_adj[4*i +: 4])
        );
    end

    always_comb begin
        state_d  = state_q;
        sr_d     = sr_q;
        bcd_d    = bcd_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        digits_d = digits_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    sr_d    = value;
                    bcd_d   = '0;
                    cnt_d   = CNT_W'(WIDTH);
                    busy_d  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // Correct every digit first, then shift the next binary bit in.
                {bcd_d, sr_d} = {w_adj[14:0], sr_q, 1'b0};
                cnt_d         = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                digits_d = bcd_q;
                done_d   = 1'b1;
                busy_d   = 1'b0;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sr_q     <= '0;
            bcd_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            digits_q <= '0;
        end else begin
            state_q  <= state_d;
            sr_q     <= sr_d;
            bcd_q    <= bcd_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            digits_q <= digits_d;
        end
    end

    always_comb begin
        scan_cnt_d = scan_cnt_q + SCAN_W'(1);
        idx_d      = idx_q;
        if (scan_cnt_q == SCAN_W'(SCAN_DIV - 1)) begin
            scan_cnt_d = '0;
            idx_d      = idx_q + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt_q <= '0;
            idx_q      <= '0;
        end else begin
            scan_cnt_q <= scan_cnt_d;
            idx_q      <= idx_d;
        end
    end

    // Leading-zero blanking: a digit blanks when it and every digit above it is zero.
    always_comb begin
        w_sel   = digits_q[4*idx_q +: 4];
        w_blank = 1'b0;
        case (idx_q)
            2'd1:    w_blank = (digits_q[15:4] == 12'd0);
            2'd2:    w_blank = (digits_q[15:8] == 8'd0);
            2'd3:    w_blank = (digits_q[15:12] == 4'd0);
            default: w_blank = 1'b0;
        endcase
    end

    assign an        = ~(4'b0001 << idx_q);
    assign seg       = w_blank ? SEG_BLANK : seg_decode(w_sel);
    assign busy      = busy_q;
    assign done      = done_q;
    assign thousands = digits_q[15:12];
    assign hundreds  = digits_q[11:8];
    assign tens      = digits_q[7:4];
    assign ones      = digits_q[3:0];

endmodule
`default_nettype wire

// File: tb/tb_bcd_seq_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_bcd_seq_ctrl
//  Description : Self-checking bench for bcd_seq_ctrl against a decimal
//                arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_seq_ctrl;

    localparam int SCAN_DIV = 4;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [10:0] value = '0;
    logic        busy, done;
    logic [3:0]  thousands, hundreds, tens, ones, an;
    logic [6:0]  seg;

    int errors   = 0;
    int checks   = 0;
    int edges    = 0;
    int disp_val = 0;

    bcd_seq_ctrl #(.WIDTH(11), .SCAN_DIV(SCAN_DIV)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .value     (value),
        .busy      (busy),
        .done      (done),
        .thousands (thousands),
        .hundreds  (hundreds),
        .tens      (tens),
        .ones      (ones),
        .an        (an),
        .seg       (seg)
    );

    always #5 clk = ~clk;

    // Clock edges seen since reset was last released.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edges <= 0;
        else        edges <= edges + 1;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] ref_digits(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [6:0] ref_font(input int d);
        case (d)
            0: return 7'b1000000;  1: return 7'b1111001;
            2: return 7'b0100100;  3: return 7'b0110000;
            4: return 7'b0011001;  5: return 7'b0010010;
            6: return 7'b0000010;  7: return 7'b1111000;
            8: return 7'b0000000;  9: return 7'b0010000;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic logic [3:0] ref_an(input int e);
        logic [3:0] a;
        a = 4'b1111;
        a[(e / SCAN_DIV) % 4] = 1'b0;
        return a;
    endfunction

    function automatic logic [6:0] ref_seg(input int v, input int e);
        int p, pw;
        p  = (e / SCAN_DIV) % 4;
        pw = (p == 0) ? 1 : (p == 1) ? 10 : (p == 2) ? 100 : 1000;
        if (p > 0 && v < pw) return 7'h7F;
        return ref_font((v / pw) % 10);
    endfunction

    function automatic logic [15:0] dut_digits();
        return {thousands, hundreds, tens, ones};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int limit, output int cyc, output bit found);
        cyc   = 0;
        found = 1'b0;
        while (!found && cyc < limit) begin
            tick();
            cyc++;
            if (done === 1'b1) found = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        repeat (3) tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_hs: busy=%b done=%b, required 0 0", busy, done);
        end
        checks++;
        if (dut_digits() !== 16'h0000) begin
            errors++;
            $display("FAIL reset_digits: got %h, required 0000", dut_digits());
        end
        checks++;
        if (an !== 4'b1110 || seg !== 7'b1000000) begin
            errors++;
            $display("FAIL reset_scan: an=%b seg=%b, required 1110 1000000", an, seg);
        end
        rst_n    = 1'b1;
        disp_val = 0;
        tick();
    endtask

    task automatic test_max();
        logic [15:0] prev;
        prev  = dut_digits();
        value = 11'd2047;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL max_accept: busy=%b done=%b, required 1 0", busy, done);
        end
        for (int n = 1; n <= 12; n++) begin
            tick();
            checks++;
            if (busy !== (n < 12) || done !== (n == 12)) begin
                errors++;
                $display("FAIL max_timing edge %0d: busy=%b done=%b, required %b %b",
                         n, busy, done, (n < 12), (n == 12));
            end
            if (n < 12) begin
                checks++;
                if (dut_digits() !== prev) begin
                    errors++;
                    $display("FAIL max_stable edge %0d: got %h, required %h", n, dut_digits(), prev);
                end
            end
        end
        checks++;
        if (dut_digits() !== ref_digits(2047)) begin
            errors++;
            $display("FAIL max_digits: got %h, required %h", dut_digits(), ref_digits(2047));
        end
        disp_val = 2047;
        tick();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL max_pulse: done=%b one cycle later, required 0", done);
        end
    endtask

    task automatic convert_and_check(input int v, input string tag);
        int cyc;
        bit found;
        value = 11'(v);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(20, cyc, found);
        checks++;
        if (!found || cyc != 12) begin
            errors++;
            $display("FAIL %s_latency: found=%0d cycles=%0d, required 1 12", tag, found, cyc);
        end
        checks++;
        if (dut_digits() !== ref_digits(v)) begin
            errors++;
            $display("FAIL %s_digits: got %h, required %h", tag, dut_digits(), ref_digits(v));
        end
        disp_val = v;
    endtask

    task automatic test_scan(input int ncyc, input string tag);
        for (int n = 0; n < ncyc; n++) begin
            tick();
            checks++;
            if (an !== ref_an(edges) || seg !== ref_seg(disp_val, edges)) begin
                errors++;
                $display("FAIL %s_scan: an=%b seg=%b, required %b %b", tag, an, seg,
                         ref_an(edges), ref_seg(disp_val, edges));
            end
        end
    endtask

    task automatic test_zero_blank();
        convert_and_check(0, "zero");
        test_scan(16, "zero");
    endtask

    task automatic test_ignore_start();
        int cyc, extra;
        bit found;
        value = 11'd905;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        value = 11'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(20, cyc, found);
        checks++;
        if (!found || cyc != 7) begin
            errors++;
            $display("FAIL ignore_latency: found=%0d cycles after edge 5=%0d, required 1 7", found, cyc);
        end
        checks++;
        if (dut_digits() !== ref_digits(905)) begin
            errors++;
            $display("FAIL ignore_digits: got %h, required %h", dut_digits(), ref_digits(905));
        end
        disp_val = 905;
        extra = 0;
        for (int n = 0; n < 20; n++) begin
            tick();
            if (done === 1'b1) extra++;
        end
        checks++;
        if (extra != 0) begin
            errors++;
            $display("FAIL ignore_single: extra done pulses=%0d, required 0", extra);
        end
        test_scan(16, "ignore");
    endtask

    task automatic test_reset_mid();
        value = 11'd1999;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (6) tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || dut_digits() !== 16'h0000) begin
            errors++;
            $display("FAIL midrst_outputs: busy=%b done=%b digits=%h, required 0 0 0000",
                     busy, done, dut_digits());
        end
        checks++;
        if (an !== 4'b1110 || seg !== 7'b1000000) begin
            errors++;
            $display("FAIL midrst_scan: an=%b seg=%b, required 1110 1000000", an, seg);
        end
        disp_val = 0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midrst_release: busy=%b done=%b, required 0 0", busy, done);
        end
        convert_and_check(37, "midrst");
    endtask

    task automatic test_back_to_back();
        int cyc, prev_edge;
        bit found;
        prev_edge = 0;
        value = 11'd0;
        start = 1'b1;
        tick();
        for (int i = 0; i <= 2047; i++) begin
            wait_done(20, cyc, found);
            checks++;
            if (!found) begin
                errors++;
                $display("FAIL b2b_timeout: value %0d gave no done", i);
            end
            checks++;
            if (dut_digits() !== ref_digits(i)) begin
                errors++;
                $display("FAIL b2b_digits value %0d: got %h, required %h", i, dut_digits(), ref_digits(i));
            end
            if (i > 0) begin
                checks++;
                if (edges - prev_edge != 13) begin
                    errors++;
                    $display("FAIL b2b_spacing value %0d: spacing %0d, required 13", i, edges - prev_edge);
                end
            end
            prev_edge = edges;
            if (i < 2047) value = 11'(i + 1);
            else          start = 1'b0;
        end
        disp_val = 2047;
        repeat (3) tick();
    endtask

    task automatic test_random();
        int v, gap;
        for (int k = 0; k < 20; k++) begin
            v   = $urandom_range(0, 2047);
            gap = $urandom_range(0, 5);
            repeat (gap) tick();
            convert_and_check(v, "rand");
            test_scan($urandom_range(1, 8), "rand");
        end
    endtask

    task automatic test_blank_ten();
        convert_and_check(10, "ten");
        test_scan(16, "ten");
    endtask

    initial begin
        test_reset();
        test_max();
        test_zero_blank();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        test_random();
        test_blank_ten();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
